// File: rtl/des_pkg.sv
// Shared definitions for the iterative DES key scheduler: widths, state
// encoding, the PC-1 / PC-2 selection tables and the per-round shift schedule.
package des_pkg;

   localparam int KEY_W    = 64;
   localparam int HALF_W   = 28;
   localparam int CD_W     = 2 * HALF_W;
   localparam int SUBKEY_W = 48;
   localparam int ROUNDS   = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // PC-1: entry j gives the DES key bit (1 = MSB) that lands in CD bit j+1.
   localparam int PC1_TAB [CD_W] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   // PC-2: entry j gives the CD bit (1 = MSB) that lands in subkey bit j+1.
   localparam int PC2_TAB [SUBKEY_W] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   // Shift schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (round 0 first).
   // Bit r is set when round r rotates by two, clear when it rotates by one.
   localparam logic [ROUNDS-1:0] SHIFT_TWO = 16'h7EFC;

   // Rotate a 28-bit half toward the MSB (DES "left") by one or two places.
   function automatic logic [HALF_W-1:0] rot_left(input logic [HALF_W-1:0] x,
                                                  input logic two);
      if (two)
         return {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
      else
         return {x[HALF_W-2:0], x[HALF_W-1]};
   endfunction

   // Rotate a 28-bit half toward the LSB by one or two places (decrypt walk).
   function automatic logic [HALF_W-1:0] rot_right(input logic [HALF_W-1:0] x,
                                                   input logic two);
      if (two)
         return {x[1:0], x[HALF_W-1:2]};
      else
         return {x[0], x[HALF_W-1:1]};
   endfunction

endpackage

// File: rtl/des_key_permute.sv
// Pure wiring: PC-1 (64 -> 56), PC-2 (56 -> 48) and the per-byte parity of
// the raw key. DES bit n (1 = MSB) of a w-bit vector is vector[w-n].
module des_key_permute
   import des_pkg::*;
(
   input  logic [KEY_W-1:0]    key,
   input  logic [CD_W-1:0]     cd,
   output logic [CD_W-1:0]     pc1,
   output logic [SUBKEY_W-1:0] pc2,
   output logic [7:0]          byte_odd
);

   for (genvar i = 0; i < CD_W; i++) begin : g_pc1
      assign pc1[CD_W-1-i] = key[KEY_W-PC1_TAB[i]];
   end

   for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
      assign pc2[SUBKEY_W-1-i] = cd[CD_W-PC2_TAB[i]];
   end

   // A byte with correct DES parity has an odd number of ones.
   for (genvar b = 0; b < 8; b++) begin : g_par
      assign byte_odd[b] = ^key[8*b +: 8];
   end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key scheduler. Loads PC-1(key) on start and then walks the
// C/D halves one subkey per handshake, forward (K1..K16) or backward
// (K16..K1). round_key_o is PC-2 of the registered halves.
//
// Handshake: round_key_o is transferred on a rising edge where both
// round_key_valid_o and round_key_ready_i are high; while valid is high and
// ready is low, round_key_o and round_idx_o hold their values.
module des_key_schedule
   import des_pkg::*;
#(
   parameter int PARITY_CHECK = 0
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [KEY_W-1:0]    key_i,
   input  logic                decrypt_i,
   input  logic                start_i,
   output logic                busy_o,
   output logic [SUBKEY_W-1:0] round_key_o,
   output logic                round_key_valid_o,
   input  logic                round_key_ready_i,
   output logic [3:0]          round_idx_o,
   output logic                done_o,
   output logic                key_parity_err_o,
   output state_t              state_o
);

   state_t            state_q;
   logic [HALF_W-1:0] c_q, d_q;
   logic [3:0]        idx_q;
   logic              decrypt_q;
   logic              valid_q;
   logic              busy_q;
   logic              done_q;
   logic              perr_q;

   logic [CD_W-1:0]   pc1_cd;
   logic [7:0]        byte_odd;
   logic [HALF_W-1:0] c_load, d_load;
   logic [HALF_W-1:0] c_step, d_step;
   logic [3:0]        idx_next;
   logic              handshake;
   logic              last;
   logic              key_bad;

   des_key_permute u_permute (
      .key      (key_i),
      .cd       ({c_q, d_q}),
      .pc1      (pc1_cd),
      .pc2      (round_key_o),
      .byte_odd (byte_odd)
   );

   assign handshake = valid_q & round_key_ready_i;
   assign last      = (idx_q == 4'd15);
   assign idx_next  = idx_q + 4'd1;
   assign key_bad   = ~&byte_odd;

   // Halves captured on start: pre-rotated for K1, raw (C16 = C0) for K16.
   always_comb begin
      c_load = pc1_cd[CD_W-1:HALF_W];
      d_load = pc1_cd[HALF_W-1:0];
      if (!decrypt_i) begin
         c_load = rot_left(pc1_cd[CD_W-1:HALF_W], SHIFT_TWO[0]);
         d_load = rot_left(pc1_cd[HALF_W-1:0], SHIFT_TWO[0]);
      end
   end

   // Halves for the next subkey in the emitted order.
   always_comb begin
      c_step = rot_left(c_q, SHIFT_TWO[idx_next]);
      d_step = rot_left(d_q, SHIFT_TWO[idx_next]);
      if (decrypt_q) begin
         c_step = rot_right(c_q, SHIFT_TWO[4'd15 - idx_q]);
         d_step = rot_right(d_q, SHIFT_TWO[4'd15 - idx_q]);
      end
   end

   // Control FSM with all status outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         c_q       <= '0;
         d_q       <= '0;
         idx_q     <= 4'd0;
         decrypt_q <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q   <= RUN;
                  c_q       <= c_load;
                  d_q       <= d_load;
                  idx_q     <= 4'd0;
                  decrypt_q <= decrypt_i;
                  valid_q   <= 1'b1;
                  busy_q    <= 1'b1;
                  perr_q    <= (PARITY_CHECK != 0) ? key_bad : 1'b0;
               end
            end
            RUN: begin
               if (handshake) begin
                  if (last) begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     idx_q   <= 4'd0;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q <= idx_next;
                     c_q   <= c_step;
                     d_q   <= d_step;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o            = busy_q;
   assign round_key_valid_o = valid_q;
   assign round_idx_o       = idx_q;
   assign done_o            = done_q;
   assign key_parity_err_o  = (PARITY_CHECK != 0) ? perr_q : 1'b0;
   assign state_o           = state_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic key 133457799BBCDFF1
// and its published subkeys K1..K16. A second instance runs with parity
// checking enabled on the same stimulus.
module tb_des_key_schedule;
   import des_pkg::*;

   localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_B = 64'h133457799BBCDFF0;
   localparam logic [63:0] KEY_X = 64'h0123456789ABCDEF;

   // K1..K16 for KEY_A.
   localparam logic [47:0] ENC [16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
   };

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] key = '0;
   logic        decrypt = 1'b0;
   logic        start = 1'b0;
   logic        ready = 1'b0;

   logic        busy, valid, done, perr;
   logic [47:0] round_key;
   logic [3:0]  idx;
   state_t      state;

   logic        busy_p, valid_p, done_p, perr_p;
   logic [47:0] round_key_p;
   logic [3:0]  idx_p;
   state_t      state_p;

   logic [6:0]  st;
   assign st = {valid, busy, done, idx};

   int n_cmp = 0;
   int n_err = 0;

   des_key_schedule dut (
      .clk (clk), .rst (rst), .key_i (key), .decrypt_i (decrypt),
      .start_i (start), .busy_o (busy), .round_key_o (round_key),
      .round_key_valid_o (valid), .round_key_ready_i (ready),
      .round_idx_o (idx), .done_o (done), .key_parity_err_o (perr),
      .state_o (state)
   );

   des_key_schedule #(.PARITY_CHECK(1)) dut_p (
      .clk (clk), .rst (rst), .key_i (key), .decrypt_i (decrypt),
      .start_i (start), .busy_o (busy_p), .round_key_o (round_key_p),
      .round_key_valid_o (valid_p), .round_key_ready_i (ready),
      .round_idx_o (idx_p), .done_o (done_p), .key_parity_err_o (perr_p),
      .state_o (state_p)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (st !== 7'b000_0000) begin n_err++; $display("FAIL reset_status: got %b expected %b", st, 7'b000_0000); end
      n_cmp++; if (round_key !== 48'h0) begin n_err++; $display("FAIL reset_key: got %h expected %h", round_key, 48'h0); end
      n_cmp++; if ({perr, perr_p} !== 2'b00) begin n_err++; $display("FAIL reset_perr: got %b expected 00", {perr, perr_p}); end
      n_cmp++; if (state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", state, IDLE); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_encrypt();
      ready = 1'b1; key = KEY_A; decrypt = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; key = KEY_X;
      for (int i = 0; i < 16; i++) begin
         n_cmp++; if (st !== {3'b110, i[3:0]}) begin n_err++; $display("FAIL enc_status[%0d]: got %b expected %b", i, st, {3'b110, i[3:0]}); end
         n_cmp++; if (round_key !== ENC[i]) begin n_err++; $display("FAIL enc_key[%0d]: got %h expected %h", i, round_key, ENC[i]); end
         @(negedge clk);
      end
      n_cmp++; if (st !== 7'b001_0000) begin n_err++; $display("FAIL enc_done: got %b expected %b", st, 7'b001_0000); end
      @(negedge clk);
      n_cmp++; if (st !== 7'b000_0000) begin n_err++; $display("FAIL enc_after_done: got %b expected %b", st, 7'b000_0000); end
   endtask

   task automatic test_decrypt();
      ready = 1'b1; key = KEY_A; decrypt = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; decrypt = 1'b0;
      for (int i = 0; i < 16; i++) begin
         n_cmp++; if (st !== {3'b110, i[3:0]}) begin n_err++; $display("FAIL dec_status[%0d]: got %b expected %b", i, st, {3'b110, i[3:0]}); end
         n_cmp++; if (round_key !== ENC[15-i]) begin n_err++; $display("FAIL dec_key[%0d]: got %h expected %h", i, round_key, ENC[15-i]); end
         @(negedge clk);
      end
      n_cmp++; if (st !== 7'b001_0000) begin n_err++; $display("FAIL dec_done: got %b expected %b", st, 7'b001_0000); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      ready = 1'b1; key = KEY_A; decrypt = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         n_cmp++; if (st !== {3'b110, i[3:0]}) begin n_err++; $display("FAIL bp_status[%0d]: got %b expected %b", i, st, {3'b110, i[3:0]}); end
         n_cmp++; if (round_key !== ENC[i]) begin n_err++; $display("FAIL bp_key[%0d]: got %h expected %h", i, round_key, ENC[i]); end
         if (i == 3) begin
            ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               @(negedge clk);
               n_cmp++; if (st !== 7'b110_0011) begin n_err++; $display("FAIL bp_stall_status[%0d]: got %b expected %b", s, st, 7'b110_0011); end
               n_cmp++; if (round_key !== ENC[3]) begin n_err++; $display("FAIL bp_stall_key[%0d]: got %h expected %h", s, round_key, ENC[3]); end
            end
            ready = 1'b1;
         end
         @(negedge clk);
      end
      n_cmp++; if (st !== 7'b001_0000) begin n_err++; $display("FAIL bp_done: got %b expected %b", st, 7'b001_0000); end
      @(negedge clk);
   endtask

   task automatic test_start_ignored_back_to_back();
      ready = 1'b1; key = KEY_A; decrypt = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         n_cmp++; if (round_key !== ENC[i]) begin n_err++; $display("FAIL ign_key[%0d]: got %h expected %h", i, round_key, ENC[i]); end
         n_cmp++; if (idx !== i[3:0]) begin n_err++; $display("FAIL ign_idx[%0d]: got %0d expected %0d", i, idx, i); end
         if (i == 7) begin
            start = 1'b1; key = KEY_X; decrypt = 1'b1;
         end
         @(negedge clk);
         start = 1'b0; key = KEY_A;
      end
      n_cmp++; if (st !== 7'b001_0000) begin n_err++; $display("FAIL ign_done: got %b expected %b", st, 7'b001_0000); end
      // New schedule requested in the done cycle.
      start = 1'b1; decrypt = 1'b1; key = KEY_A;
      @(negedge clk);
      start = 1'b0; decrypt = 1'b0;
      for (int i = 0; i < 16; i++) begin
         n_cmp++; if (st !== {3'b110, i[3:0]}) begin n_err++; $display("FAIL b2b_status[%0d]: got %b expected %b", i, st, {3'b110, i[3:0]}); end
         n_cmp++; if (round_key !== ENC[15-i]) begin n_err++; $display("FAIL b2b_key[%0d]: got %h expected %h", i, round_key, ENC[15-i]); end
         @(negedge clk);
      end
      n_cmp++; if (st !== 7'b001_0000) begin n_err++; $display("FAIL b2b_done: got %b expected %b", st, 7'b001_0000); end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      ready = 1'b1; key = KEY_A; decrypt = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      n_cmp++; if (st !== 7'b110_1001) begin n_err++; $display("FAIL abort_pre: got %b expected %b", st, 7'b110_1001); end
      rst = 1'b1;
      #1;
      n_cmp++; if (st !== 7'b000_0000) begin n_err++; $display("FAIL abort_status: got %b expected %b", st, 7'b000_0000); end
      @(negedge clk);
      rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         n_cmp++; if (st !== 7'b000_0000) begin n_err++; $display("FAIL abort_idle[%0d]: got %b expected %b", s, st, 7'b000_0000); end
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         n_cmp++; if (round_key !== ENC[i]) begin n_err++; $display("FAIL abort_restart_key[%0d]: got %h expected %h", i, round_key, ENC[i]); end
         @(negedge clk);
      end
      n_cmp++; if (st !== 7'b001_0000) begin n_err++; $display("FAIL abort_restart_done: got %b expected %b", st, 7'b001_0000); end
      @(negedge clk);
   endtask

   task automatic test_parity();
      ready = 1'b1; key = KEY_A; decrypt = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if ({perr_p, perr} !== 2'b00) begin n_err++; $display("FAIL par_good: got %b expected 00", {perr_p, perr}); end
      n_cmp++; if (round_key_p !== ENC[0]) begin n_err++; $display("FAIL par_good_key: got %h expected %h", round_key_p, ENC[0]); end
      repeat (16) @(negedge clk);
      n_cmp++; if ({done_p, perr_p} !== 2'b10) begin n_err++; $display("FAIL par_good_done: got %b expected 10", {done_p, perr_p}); end
      key = KEY_B; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if ({perr_p, perr} !== 2'b10) begin n_err++; $display("FAIL par_bad: got %b expected 10", {perr_p, perr}); end
      n_cmp++; if (round_key_p !== ENC[0]) begin n_err++; $display("FAIL par_bad_key_p: got %h expected %h", round_key_p, ENC[0]); end
      n_cmp++; if (round_key !== ENC[0]) begin n_err++; $display("FAIL par_bad_key: got %h expected %h", round_key, ENC[0]); end
      repeat (15) @(negedge clk);
      n_cmp++; if ({valid_p, idx_p, round_key_p} !== {1'b1, 4'd15, ENC[15]}) begin n_err++; $display("FAIL par_bad_k16: got %h expected %h", {valid_p, idx_p, round_key_p}, {1'b1, 4'd15, ENC[15]}); end
      @(negedge clk);
      n_cmp++; if ({done_p, busy_p, perr_p} !== 3'b101) begin n_err++; $display("FAIL par_sticky: got %b expected 101", {done_p, busy_p, perr_p}); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_encrypt();
      test_decrypt();
      test_backpressure();
      test_start_ignored_back_to_back();
      test_reset_abort();
      test_parity();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Iterative DES key scheduler that sits directly upstream of the DES round datapath.
- On start, it takes a 64-bit key and emits the sixteen 48-bit round subkeys, one per handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Each subkey feeds the round_key input of the round stage. A valid/ready handshake lets the round sequencer stall it.

Parameters:
- PARITY_CHECK, default 0: if 1, check odd parity of each key byte when start is accepted, and report the result on key_parity_err_o.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- key_i  input  64  DES key; bit 1 (DES numbering) = key_i[63]; parity bits ignored by PC-1
- decrypt_i  input  1  sampled with start_i; 0 = K1 first, 1 = K16 first
- start_i  input  1  request a new schedule; accepted only when busy_o=0
- busy_o  output  1  high from the cycle after start acceptance until the final handshake
- round_key_o  output  48  current subkey = PC-2 of the registered C,D halves
- round_key_valid_o  output  1  round_key_o holds a valid subkey
- round_key_ready_i  input  1  consumer accepts round_key_o when valid and ready are both high
- round_idx_o  output  4  0..15, position of the current subkey in the emitted sequence
- done_o  output  1  one-cycle pulse after the 16th handshake
- key_parity_err_o  output  1  sticky per schedule; tied 0 when PARITY_CHECK=0

Behaviour:
- Reset (asynchronous): state IDLE; C=D=0; busy_o=0; round_key_valid_o=0; round_idx_o=0; done_o=0; key_parity_err_o=0; round_key_o=PC-2(0)=0.
- States: IDLE and RUN.
- IDLE -> RUN on start_i, capturing the key:
  - CD = PC-1(key_i), giving C and D of 28 bits each.
  - Encrypt: C and D are each rotated left 1 bit before being registered, so the first output is K1.
  - Decrypt: CD is registered unrotated, so the first output is K16 (C16=C0, D16=D0).
  - round_idx=0; mode latched; key_parity_err_o updated.
- RUN: round_key_valid_o=1.
  - Hold CD and round_idx while ready is low; round_key_o must stay stable.
  - On a handshake with round_idx<15: round_idx increments, and CD updates for the next key.
  - Encrypt update: rotate C and D left by SHIFT[round_idx+1].
  - Decrypt update: rotate C and D right by SHIFT[15-round_idx].
  - SHIFT (0-based) = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- On the handshake with round_idx=15: go to IDLE; valid=0; busy_o=0; round_idx=0; done_o=1 for the next cycle only.
- Latency: the first subkey is valid 1 cycle after start acceptance. With ready held high, 16 keys take 16 cycles and done_o follows on cycle 17.
- start_i during RUN is ignored; key_i and decrypt_i are not re-sampled.
- start_i in the done_o cycle is accepted (IDLE), so back-to-back schedules are possible.
- key_i changes after acceptance have no effect.
- Reset asserted mid-schedule aborts immediately: valid drops, no done_o pulse.
- After the full encrypt rotations the total shift is 28, so CD returns to C0D0; this is used for verification.

Decomposition:
- Shared package des_pkg:
  - PC-1 and PC-2 index tables.
  - SHIFT schedule constant.
  - State encoding (IDLE, RUN).
  - Widths: KEY_W=64, HALF_W=28, SUBKEY_W=48.
- One sub-module, des_key_permute: pure-wiring PC-1 (64->56) and PC-2 (56->48). It is reused by the verification model.

Test Plan:
- Encrypt, key 133457799BBCDFF1, ready held 1:
  - round_key_o = 1B02EFFC7072 at idx 0, then 79AED9DBC9E5 at idx 1.
  - CB3D8B0E17F5 at idx 15.
  - done_o on the 17th cycle after start.
- Decrypt, same key: idx 0 = CB3D8B0E17F5, idx 15 = 1B02EFFC7072, and the full sequence is the exact reverse of the encrypt run.
- Backpressure: ready low for 5 cycles at idx 3 -> round_key_o and idx stable, valid stays 1, no skipped or duplicated keys.
- start_i pulsed at idx 7 with a different key -> ignored; sequence completes with the original key. A new start in the done_o cycle is accepted.
- rst asserted at idx 9 -> next sample shows valid=0, busy_o=0, idx=0; no done_o; a fresh start then produces K1 correctly.
- PARITY_CHECK=1: key 133457799BBCDFF1 gives err=0; flipping bit 0 (key 133457799BBCDFF0) gives err=1, while the subkeys are unchanged.
